stream_beat_packer: RTL
=======================

# stream_beat_packer

Single-clock stream packer that sits directly downstream of the gray-code CDC FIFO in the destination clock domain. It gathers `RATIO` consecutive narrow beats into one wide word, with a per-lane strobe, and hands the word on through a registered valid/ready output. A word is emitted early on an input `last` marker, or when a partially filled word has sat idle for `TIMEOUT` cycles.

## Interface
Parameters:
- `IN_WIDTH`, default 8: width of one input beat in bits.
- `RATIO`, default 4: beats per output word; must be ≥ 2.
- `TIMEOUT`, default 16: number of idle cycles before a partial word is flushed; 0 disables the timeout.
- `OUT_WIDTH` (localparam) = `IN_WIDTH*RATIO`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_data_i`  in  IN_WIDTH  input beat.
- `in_last_i`  in  1  beat closes the current word.
- `in_valid_i`  in  1  input valid.
- `in_ready_o`  out  1  input ready.
- `out_data_o`  out  OUT_WIDTH  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- `out_strb_o`  out  RATIO  bit k set when lane k holds a beat.
- `out_last_o`  out  1  word was closed by `in_last_i`.
- `out_valid_o`  out  1  output valid.
- `out_ready_i`  in  1  output ready.

## Operation
State:
- Accumulator `acc` (OUT_WIDTH bits).
- Fill count `cnt` (0..RATIO-1).
- Idle counter `idle`, $clog2(TIMEOUT+1) bits.
- Output register holding data, strobe, last and valid.

Rules:
- `slot_free` = !out_valid_o | out_ready_i.
- `in_ready_o` = `slot_free`. This is a combinational path from `out_ready_i`; it is intentional.
- Accepted beat (in_valid_i & in_ready_o): written to lane `cnt` of the word.
- Completion when the accepted beat has `cnt == RATIO-1` or `in_last_i == 1`:
  - The output register loads the accumulator merged with the current beat.
  - Strobe = lanes 0..cnt.
  - `out_last_o` = `in_last_i`.
  - `acc` is cleared to 0 and `cnt` to 0.
- Non-completing accepted beat: `cnt` increments and `idle` clears.
- Unfilled lanes of `out_data_o` are always 0.
- Timeout (TIMEOUT > 0):
  - `idle` increments in each cycle where `cnt > 0` and no beat is accepted (`in_ready_o` is low or `in_valid_i` is low).
  - `idle` clears whenever a beat is accepted or `cnt == 0`.
  - When `idle == TIMEOUT-1` and `slot_free`, that cycle flushes: the output loads `acc`, strobe = lanes 0..cnt-1, `out_last_o` = 0, and `acc`, `cnt` and `idle` clear.
  - If the slot is not free, `idle` saturates and the flush happens in the first cycle the slot is free.
  - A flush never coincides with an accepted beat, because an accept clears `idle`.
- Output handshake: `out_valid_o` is set on completion or flush. It clears on out_valid_o & out_ready_i unless a new completion or flush happens in the same cycle, in which case the register reloads with no bubble.
- Output contents are held stable while out_valid_o & !out_ready_i.
- Reset:
  - All registers clear: `out_valid_o`, `out_data_o`, `out_strb_o` and `out_last_o` read 0; `cnt`, `idle` and `acc` are 0.
  - `in_ready_o` reads 1 in the first cycle after reset.
  - Reset mid-word discards the partial word and any pending output word without emitting them.
- A beat presented while `rst_i` is high is not accepted.

## Timing
- Latency: the output word is valid in the cycle after the completing beat is accepted.
- Throughput: one beat per cycle sustained when `out_ready_i` is held high; full-word output rate is 1 word per RATIO cycles.
- Timeout: with the last beat accepted in cycle 0, the idle cycles are 1..TIMEOUT. The flush happens in cycle TIMEOUT and `out_valid_o` rises in cycle TIMEOUT+1.
- Backpressure: with out_valid_o & !out_ready_i, `in_ready_o` is 0. Accumulation of further beats stalls too; no beat is lost or duplicated.
- All outputs except `in_ready_o` come directly from registers.

## Test plan
All scenarios use IN_WIDTH=8, RATIO=4, TIMEOUT=8.
- Full word: beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready_i=1 -> one cycle after 0x44 is accepted: out_data_o=0x44332211, out_strb_o=0xF, out_last_o=0; `in_ready_o` stays 1 throughout.
- Early last: beats 0xAA, then 0xBB with in_last_i=1 -> out_data_o=0x0000BBAA, out_strb_o=0x3, out_last_o=1; the next word starts at lane 0.
- Timeout: single beat 0x5A accepted in cycle 0, then idle -> out_valid_o rises in cycle 9 with out_data_o=0x0000005A, out_strb_o=0x1, out_last_o=0.
- Backpressure: 8 beats 0x01..0x08 with out_ready_i=0 until cycle 10 -> `in_ready_o` is 0 from the cycle after the first word completes. Words come out in order: 0x04030201, then 0x08070605. No beat is lost or duplicated.
- Streaming: 12 beats back-to-back with out_ready_i=1 -> 3 words, each 1 cycle after its 4th beat; `in_ready_o` is never 0.
- Reset mid-word: beats 0xC1, 0xC2, then rst_i=1 for 1 cycle, then 0x01..0x04 -> only 0x04030201 is emitted; `out_valid_o` is 0 in the cycle after reset.

Source files
------------

// File: rtl/stream_beat_packer.sv
// Packs RATIO narrow input beats into one wide word with per-lane strobes.
// Words close on a full count, an input last marker, or an idle timeout.
module stream_beat_packer #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4,
   parameter int TIMEOUT  = 16,
   localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IN_WIDTH-1:0]  in_data_i,
   input  logic                 in_last_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic [RATIO-1:0]     out_strb_o,
   output logic                 out_last_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i
);

   localparam int CNT_W  = $clog2(RATIO);
   localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RATIO - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;
   localparam bit TIMEOUT_EN = (TIMEOUT > 0);

   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [RATIO-1:0]     out_strb_q, out_strb_d;
   logic                 out_last_q, out_last_d;
   logic                 out_valid_q, out_valid_d;

   logic                 slot_free;
   logic                 accept;
   logic                 complete;
   logic                 flush;
   logic [OUT_WIDTH-1:0] acc_merged;
   logic [RATIO-1:0]     full_strb;
   logic [RATIO-1:0]     part_strb;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         idle_q      <= '0;
         out_data_q  <= '0;
         out_strb_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         idle_q      <= idle_d;
         out_data_q  <= out_data_d;
         out_strb_q  <= out_strb_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      slot_free  = !out_valid_q || out_ready_i;
      accept     = in_valid_i && slot_free;
      complete   = accept && ((cnt_q == CNT_LAST) || in_last_i);
      // An accepted beat always wins over a pending flush in the same cycle.
      flush      = TIMEOUT_EN && (cnt_q != '0) && (idle_q == IDLE_LAST) && slot_free && !accept;
      acc_merged = acc_q;
      acc_merged[cnt_q*IN_WIDTH +: IN_WIDTH] = in_data_i;
      for (int k = 0; k < RATIO; k++) begin
         full_strb[k] = (k <= int'(cnt_q));
         part_strb[k] = (k < int'(cnt_q));
      end
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      idle_d      = idle_q;
      out_data_d  = out_data_q;
      out_strb_d  = out_strb_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !out_ready_i;

      if (complete) begin
         out_data_d  = acc_merged;
         out_strb_d  = full_strb;
         out_last_d  = in_last_i;
         out_valid_d = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
         idle_d      = '0;
      end else if (accept) begin
         acc_d  = acc_merged;
         cnt_d  = cnt_q + 1'b1;
         idle_d = '0;
      end else if (flush) begin
         out_data_d  = acc_q;
         out_strb_d  = part_strb;
         out_last_d  = 1'b0;
         out_valid_d = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
         idle_d      = '0;
      end else if (TIMEOUT_EN && (cnt_q != '0)) begin
         idle_d = (idle_q == IDLE_LAST) ? idle_q : idle_q + 1'b1;
      end else begin
         idle_d = '0;
      end
   end

   assign in_ready_o  = slot_free;
   assign out_data_o  = out_data_q;
   assign out_strb_o  = out_strb_q;
   assign out_last_o  = out_last_q;
   assign out_valid_o = out_valid_q;

endmodule
